instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose: groups the program-byte load handshake and the instruction issue
// bus of instr_fetch_unit into one bundle.
//
// Signals:
//   byte_in     [7:0]   program byte, high byte of an instruction first
//   byte_valid          byte_in carries a byte this cycle
//   byte_ready          fetch unit can take a byte; transfer when both high
//   instruction [15:0]  registered instruction word for the compute unit
//   instr_valid         registered; instruction is a new issue this cycle
//
// Modports:
//   master  - byte source / instruction consumer (testbench, loader)
//   slave   - the fetch unit itself
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction;
    logic        instr_valid;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  instruction,
        input  instr_valid
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output instruction,
        output instr_valid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: loads a program of up to 16 sixteen-bit instructions as a byte
// stream (high byte first), then on 'run' issues them one per enabled cycle
// to a downstream compute unit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        issue enable while running
//   run        level; starts/sustains issue, low aborts or ends it
//   clear      pulse; empties program memory (ignored while running)
//   bus        instr_fetch_unit_if.slave: byte load handshake + issue bus
//   pc         index of the next entry to issue
//   prog_len   number of loaded instructions, 0..16
//   busy       high in RUN and DONE
//
// Configuration:
//   IFU_LOOP_EN  when defined, issue wraps from the last entry back to entry 0
//                and continues while run stays high (DONE is never entered).
//                When undefined, issuing the last entry moves to DONE.
// -----------------------------------------------------------------------------
module instr_fetch_unit (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               run,
    input  logic               clear,
    instr_fetch_unit_if.slave  bus,
    output logic [3:0]         pc,
    output logic [4:0]         prog_len,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [3:0]  pc_q, pc_n;
    logic [4:0]  len_q, len_n;
    logic [7:0]  hi_q, hi_n;
    logic [15:0] instr_q, instr_n;
    logic        valid_q, valid_n;

    logic [15:0] mem [16];
    logic        mem_we;
    logic        ready;
    logic        accept;
    logic [3:0]  last_idx;

    // Loading is only possible with room left and no run/clear competing;
    // run therefore has priority over a byte offered in IDLE.
    assign ready  = ((state == IDLE) && !run && !clear && (len_q < 5'd16)) ||
                    ((state == LOAD_LO) && !clear);
    assign accept = bus.byte_valid && ready;

    // Index of the final loaded entry; modulo 16 so a full program (16) gives 15.
    assign last_idx = len_q[3:0] - 4'd1;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_n = state;
        pc_n    = pc_q;
        len_n   = len_q;
        hi_n    = hi_q;
        instr_n = instr_q;
        valid_n = 1'b0;
        mem_we  = 1'b0;

        case (state)
            IDLE: begin
                if (clear) begin
                    len_n = 5'd0;
                    hi_n  = 8'h00;
                end else if (run) begin
                    // An empty program cannot start; stay put until loaded.
                    if (len_q != 5'd0) begin
                        pc_n    = 4'd0;
                        state_n = RUN;
                    end
                end else if (accept) begin
                    hi_n    = bus.byte_in;
                    state_n = LOAD_LO;
                end
            end

            LOAD_LO: begin
                if (clear) begin
                    len_n   = 5'd0;
                    hi_n    = 8'h00;
                    state_n = IDLE;
                end else if (accept) begin
                    mem_we  = !len_q[4];
                    len_n   = len_q[4] ? len_q : len_q + 5'd1;
                    state_n = IDLE;
                end
            end

            RUN: begin
                if (!run) begin
                    // Abort: leave a No-Op on the bus for the compute unit.
                    state_n = IDLE;
                    instr_n = 16'h0000;
                end else if (ena) begin
                    instr_n = mem[pc_q];
                    valid_n = 1'b1;
                    if (pc_q == last_idx) begin
`ifdef IFU_LOOP_EN
                        pc_n = 4'd0;
`else
                        pc_n    = pc_q + 4'd1;
                        state_n = DONE;
`endif
                    end else begin
                        pc_n = pc_q + 4'd1;
                    end
                end
            end

            DONE: begin
                instr_n = 16'h0000;
                if (!run) begin
                    pc_n    = 4'd0;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= 4'd0;
            len_q   <= 5'd0;
            hi_q    <= 8'h00;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            len_q   <= len_n;
            hi_q    <= hi_n;
            instr_q <= instr_n;
            valid_q <= valid_n;
        end
    end

    // NOTE: the program memory has no reset; prog_len alone defines which
    // entries are meaningful, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_q[3:0]] <= {hi_q, bus.byte_in};
        end
    end

    assign bus.byte_ready  = ready;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign prog_len        = len_q;
    assign busy            = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The reference model is a queue of
// loaded instruction words plus an issue index: each enabled running cycle the
// next queued word must appear, and the end of the queue either stops issue
// or wraps to the start when IFU_LOOP_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic       clear;
    logic [3:0] pc;
    logic [4:0] prog_len;
    logic       busy;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .run      (run),
        .clear    (clear),
        .bus      (bus),
        .pc       (pc),
        .prog_len (prog_len),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the words the program memory should hold, in load order.
    logic [15:0] prog [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        run            = 1'b0;
        ena            = 1'b0;
        clear          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        tick;
        rst_n = 1'b1;
        prog.delete();
    endtask

    task automatic load_word(input logic [15:0] w);
        #1;
        check("load_ready_hi", bus.byte_ready, 1);
        bus.byte_in    = w[15:8];
        bus.byte_valid = 1'b1;
        tick;
        check("load_ready_lo", bus.byte_ready, 1);
        bus.byte_in = w[7:0];
        tick;
        bus.byte_valid = 1'b0;
        if (prog.size() < 16) prog.push_back(w);
    endtask

    // Start the loaded program and compare every cycle against the model.
    // mode 0: ena always 1; mode 1: random ena; mode 2: ena 1,0,1,0...
    // clear is pulsed randomly throughout and must have no effect.
    task automatic run_prog(input int cycles, input int mode);
        int          idx;
        int          len;
        bit          finished;
        logic [15:0] exp_instr;
        logic        exp_valid;
        idx       = 0;
        len       = prog.size();
        finished  = 1'b0;
        exp_instr = 16'h0000;
        run       = 1'b1;
        #1;
        check("ready_blocked_by_run", bus.byte_ready, 0);
        tick;
        bus.byte_valid = 1'b0;
        check("start_valid", bus.instr_valid, 0);
        check("start_pc", pc, 0);
        check("start_busy", busy, 1);
        for (int c = 0; c < cycles; c++) begin
            case (mode)
                0:       ena = 1'b1;
                1:       ena = 1'($urandom_range(0, 1));
                default: ena = (c % 2 == 0);
            endcase
            clear = ($urandom_range(0, 3) == 0);
            tick;
            if (finished) begin
                exp_instr = 16'h0000;
                exp_valid = 1'b0;
            end else if (ena) begin
                exp_instr = prog[idx];
                exp_valid = 1'b1;
                idx++;
                if (idx == len) begin
`ifdef IFU_LOOP_EN
                    idx = 0;
`else
                    finished = 1'b1;
`endif
                end
            end else begin
                exp_valid = 1'b0;
            end
            check("issue_instr", bus.instruction, exp_instr);
            check("issue_valid", bus.instr_valid, exp_valid);
            check("issue_pc", pc, idx % 16);
            check("issue_busy", busy, 1);
            check("issue_len_kept", prog_len, len);
        end
        clear = 1'b0;
        ena   = 1'b1;
        run   = 1'b0;
        tick;
        check("stop_valid", bus.instr_valid, 0);
        check("stop_instr", bus.instruction, 0);
        check("stop_busy", busy, 0);
        if (finished) check("stop_pc", pc, 0);
        ena = 1'b0;
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        ena            = 1'b0;
        run            = 1'b0;
        clear          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_instr", bus.instruction, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_len", prog_len, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.byte_ready, 1);

        // Three-instruction program; a byte offered together with run is refused
        load_word(16'h1205);
        load_word(16'h130A);
        load_word(16'h2201);
        check("len_three", prog_len, 3);
        bus.byte_in    = 8'hFF;
        bus.byte_valid = 1'b1;
        run_prog(5, 0);
        check("len_after_run_priority", prog_len, 3);

        // ena toggling: no entry skipped or duplicated
        run_prog(7, 2);

        // Clear discards a latched high byte
        do_reset;
        bus.byte_in    = 8'h12;
        bus.byte_valid = 1'b1;
        tick;
        bus.byte_valid = 1'b0;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check("clear_len", prog_len, 0);
        check("clear_busy", busy, 0);
        load_word(16'h3456);
        check("clear_reload_len", prog_len, 1);
        run_prog(3, 0);

        // Full program: saturation and refusal of a 17th byte
        do_reset;
        for (int i = 0; i < 16; i++) load_word(16'($urandom));
        check("full_len", prog_len, 16);
        #1;
        check("full_ready", bus.byte_ready, 0);
        bus.byte_in    = 8'hAA;
        bus.byte_valid = 1'b1;
        tick;
        tick;
        bus.byte_valid = 1'b0;
        check("full_len_kept", prog_len, 16);
        check("full_busy", busy, 0);
        run_prog(40, 1);

        // Random programs, emptied alternately by reset and by clear
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) begin
                do_reset;
            end else begin
                clear = 1'b1;
                tick;
                clear = 1'b0;
                prog.delete();
                check("rand_clear_len", prog_len, 0);
            end
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) load_word(16'($urandom));
            check("rand_len", prog_len, n);
            run_prog(2 * n + 3, 1);
        end

        // Two-instruction program held running (wraps when looping is built in)
        do_reset;
        load_word(16'hA0A0);
        load_word(16'hB0B0);
        run_prog(7, 0);

        // Asynchronous reset mid-run, then run on an empty program
        do_reset;
        load_word(16'h1111);
        load_word(16'h2222);
        load_word(16'h3333);
        run = 1'b1;
        ena = 1'b1;
        tick;
        tick;
        tick;
        check("midrun_pc", pc, 2);
        check("midrun_valid", bus.instr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", bus.instr_valid, 0);
        check("async_pc", pc, 0);
        check("async_len", prog_len, 0);
        check("async_busy", busy, 0);
        rst_n = 1'b1;
        prog.delete();
        tick;
        tick;
        tick;
        check("empty_run_busy", busy, 0);
        check("empty_run_valid", bus.instr_valid, 0);
        check("empty_run_pc", pc, 0);
        run = 1'b0;
        ena = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
